// File: rtl/gpio_cond_pkg.sv
// rtl/gpio_cond_pkg.sv - shared constants and sizing helpers for the GPIO input conditioner
//   GPIO_DIR_IN / GPIO_DIR_OUT : direction encoding used on gpio_dir_i
//   cnt_width()                : width of a per-bit debounce counter
//   pcnt_width()               : width of the shared tick prescaler
package gpio_cond_pkg;

  localparam logic GPIO_DIR_IN  = 1'b0;
  localparam logic GPIO_DIR_OUT = 1'b1;

  // Counter must hold 0..debounce_ticks; never narrower than one bit.
  function automatic int cnt_width(input int debounce_ticks);
    int w;
    w = $clog2(debounce_ticks + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

  // Prescaler holds 0..prescale-1; PRESCALE=1 still needs a one-bit register.
  function automatic int pcnt_width(input int prescale);
    int w;
    w = $clog2(prescale);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// rtl/gpio_debounce_bit.sv - one GPIO bit: synchronizer, tick debouncer, level and edge events
//   clk, rst        : clock, synchronous active-high reset
//   i_pad           : raw asynchronous pad sample
//   i_dir           : 1 = pin driven as output, 0 = input
//   i_debounce_en   : 1 = filter input transitions through the debouncer
//   i_tick          : debounce sample strobe from the shared prescaler
//   o_level         : conditioned level
//   o_rise / o_fall : registered one-cycle accepted-edge pulses
//   o_rise_next / o_fall_next : values the pulse registers load on this edge
module gpio_debounce_bit
  import gpio_cond_pkg::*;
#(
  parameter int   SYNC_STAGES    = 2,
  parameter int   DEBOUNCE_TICKS = 8,
  parameter logic RESET_LEVEL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pad,
  input  logic i_dir,
  input  logic i_debounce_en,
  input  logic i_tick,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_rise_next,
  output logic o_fall_next
);

  localparam int            CW       = cnt_width(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_stable;
  logic                   r_rise;
  logic                   r_fall;

  logic [CW-1:0] w_cnt_next;
  logic          w_stable_next;
  logic          w_sync;
  logic          w_is_in;
  logic          w_follow;

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_is_in  = (i_dir == GPIO_DIR_IN);
  // Output pins and undebounced inputs track the synchronizer directly.
  assign w_follow = (i_dir == GPIO_DIR_OUT) || !i_debounce_en;

  always_comb begin
    w_stable_next = r_stable;
    w_cnt_next    = '0;
    if (w_follow) begin
      w_stable_next = w_sync;
    end else if (w_sync != r_stable) begin
      // Pending: the counter only advances on a tick; a return to the
      // stable level falls into the default above and clears it at once.
      w_cnt_next = r_cnt;
      if (i_tick) begin
        if (r_cnt == CNT_LAST) begin
          w_stable_next = w_sync;
          w_cnt_next    = '0;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
    end
  end

  // Events are suppressed for output pins so driven read-back never interrupts.
  assign o_rise_next = w_is_in &  w_stable_next & ~r_stable;
  assign o_fall_next = w_is_in & ~w_stable_next &  r_stable;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= {SYNC_STAGES{RESET_LEVEL}};
      r_cnt    <= '0;
      r_stable <= RESET_LEVEL;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], i_pad};
      r_cnt    <= w_cnt_next;
      r_stable <= w_stable_next;
      r_rise   <= o_rise_next;
      r_fall   <= o_fall_next;
    end
  end

  assign o_level = r_stable;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/gpio_input_conditioner.sv
// rtl/gpio_input_conditioner.sv - per-bit synchronize/debounce of pad inputs for the SoC gpio_in bus
//   clk, rst       : clock, synchronous active-high reset
//   pad_i          : raw asynchronous pad values
//   gpio_dir_i     : per-bit direction, 1 = output, 0 = input
//   debounce_en_i  : per-bit debounce enable
//   gpio_o         : conditioned levels
//   rise_o, fall_o : one-cycle accepted-edge pulses per bit
//   event_o        : registered OR of all rise/fall pulses
module gpio_input_conditioner
  import gpio_cond_pkg::*;
#(
  parameter int   NUM_GPIO       = 32,
  parameter int   SYNC_STAGES    = 2,
  parameter int   PRESCALE       = 100,
  parameter int   DEBOUNCE_TICKS = 8,
  parameter logic RESET_LEVEL    = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_GPIO-1:0] pad_i,
  input  logic [NUM_GPIO-1:0] gpio_dir_i,
  input  logic [NUM_GPIO-1:0] debounce_en_i,
  output logic [NUM_GPIO-1:0] gpio_o,
  output logic [NUM_GPIO-1:0] rise_o,
  output logic [NUM_GPIO-1:0] fall_o,
  output logic                event_o
);

  localparam int            PW        = pcnt_width(PRESCALE);
  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pcnt;
  logic          r_event;
  logic          w_tick;

  logic [NUM_GPIO-1:0] w_rise_next;
  logic [NUM_GPIO-1:0] w_fall_next;

  // With PRESCALE=1 the counter sits at 0 and every cycle is a tick.
  assign w_tick = (r_pcnt == PCNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + PW'(1);
    end
  end

  for (genvar g = 0; g < NUM_GPIO; g++) begin : g_bit
    gpio_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .RESET_LEVEL    (RESET_LEVEL)
    ) u_bit (
      .clk           (clk),
      .rst           (rst),
      .i_pad         (pad_i[g]),
      .i_dir         (gpio_dir_i[g]),
      .i_debounce_en (debounce_en_i[g]),
      .i_tick        (w_tick),
      .o_level       (gpio_o[g]),
      .o_rise        (rise_o[g]),
      .o_fall        (fall_o[g]),
      .o_rise_next   (w_rise_next[g]),
      .o_fall_next   (w_fall_next[g])
    );
  end

  // Built from next-state pulses so it lands on the same edge as rise_o/fall_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_event <= 1'b0;
    end else begin
      r_event <= |(w_rise_next | w_fall_next);
    end
  end

  assign event_o = r_event;

endmodule

// File: doc/gpio_input_conditioner.md
Name: gpio_input_conditioner

Overview:
- Sits directly upstream of the SoC `gpio_in` bus.
- Takes raw bidirectional-pad input samples and hands the SoC a clean, synchronous, debounced level per bit.
- Per-bit synchronizer, then tick-based debouncer, then registered level plus rise/fall event pulses.
- Event pulses feed the GPIO interrupt logic; bits configured as outputs bypass debounce so read-back of driven pins stays fast.

Parameters:
- NUM_GPIO, 32: number of GPIO bits.
- SYNC_STAGES, 2: flip-flops in each input synchronizer chain; legal values are 2 or more.
- PRESCALE, 100: `clk` cycles per debounce sample tick; legal values are 1 or more.
- DEBOUNCE_TICKS, 8: consecutive ticks a changed level must persist before it is accepted; legal values are 1 or more.
- RESET_LEVEL, 1'b0: value of every conditioned bit after reset.

Ports:
- clk  in  1  system clock, the PLL output domain.
- rst  in  1  synchronous, active-high reset.
- pad_i  in  NUM_GPIO  raw pad input values (asynchronous).
- gpio_dir_i  in  NUM_GPIO  SoC direction; 1 = output, 0 = input.
- debounce_en_i  in  NUM_GPIO  per-bit debounce enable (quasi-static, software-written).
- gpio_o  out  NUM_GPIO  conditioned level, wired to SoC `gpio_in`.
- rise_o  out  NUM_GPIO  one-cycle pulse on an accepted 0->1 transition.
- fall_o  out  NUM_GPIO  one-cycle pulse on an accepted 1->0 transition.
- event_o  out  1  OR of all `rise_o` and `fall_o` bits, registered.

Behaviour:
- Reset (on any `clk` edge with `rst`=1):
  - Synchronizer flops are set to RESET_LEVEL.
  - `gpio_o` is set to RESET_LEVEL.
  - Per-bit counters, the prescaler, `rise_o`, `fall_o` and `event_o` are cleared to 0.
  - A debounce in progress is discarded.
- Synchronizer:
  - `sync[b]` is the last stage of a SYNC_STAGES chain.
  - `sync` reflects `pad_i` SYNC_STAGES edges after the pad changes.
- Prescaler:
  - Counter `pcnt` runs 0..PRESCALE-1 and wraps to 0.
  - `tick` = (`pcnt` == PRESCALE-1) and is combinational from `pcnt`.
  - PRESCALE=1 gives `tick` every cycle.
- Per bit, the register `stable[b]` drives `gpio_o[b]`. Counter `cnt[b]` has width clog2(DEBOUNCE_TICKS+1).
- Per-bit mode FOLLOW, entered when `gpio_dir_i[b]`=1 or `debounce_en_i[b]`=0:
  - `stable` <= `sync` every cycle; `cnt` <= 0.
  - Pad-to-`gpio_o` latency is SYNC_STAGES+1 edges.
- Per-bit mode FILTER, entered when `gpio_dir_i[b]`=0 and `debounce_en_i[b]`=1:
  - IDLE (`sync`==`stable`): `cnt` <= 0.
  - PENDING (`sync`!=`stable`):
    - On `tick`: if `cnt`==DEBOUNCE_TICKS-1, then `stable` <= `sync` and `cnt` <= 0; otherwise `cnt`++.
    - Without `tick`: hold.
  - Glitch: if `sync` returns to `stable` while PENDING, `cnt` <= 0 the same cycle, with no change and no pulse.
  - Acceptance latency after `sync` changes is between (DEBOUNCE_TICKS-1)*PRESCALE+1 and DEBOUNCE_TICKS*PRESCALE edges, depending on prescaler phase.
- Mode switch mid-count (`debounce_en_i` or `gpio_dir_i` changes): the new mode applies next edge. A switch into FOLLOW clears `cnt` and loads `sync`.
- Events:
  - `rise_o[b]` and `fall_o[b]` are registered on the same edge that `stable` changes, so they are coincident with the new `gpio_o` value.
  - Asserted only when `gpio_dir_i[b]`=0 at that edge.
  - The FOLLOW-mode input path (`debounce_en_i`=0, `gpio_dir_i`=0) still generates events.
- `event_o` is registered from the next-state OR of all rise/fall bits, so it is coincident with them.
- `rise_o` and `fall_o` are never both 1 for the same bit. Pulses never exceed 1 cycle.
- All bits are independent; multiple bits may change on the same edge.

Decomposition:
- Package `gpio_cond_pkg`:
  - `GPIO_DIR_IN`=0 and `GPIO_DIR_OUT`=1 constants, matching the top-level direction encoding.
  - Function `cnt_width(DEBOUNCE_TICKS)`.
- Sub-module `gpio_debounce_bit`: one instance per bit via generate; contains synchronizer, counter, `stable`, and edge logic; takes `tick` as an input.
- Top: shared prescaler, generate loop, and the `event_o` OR register.

Test Plan (bench parameters PRESCALE=4, DEBOUNCE_TICKS=3, SYNC_STAGES=2, RESET_LEVEL=0):
- Reset: hold `rst` 3 cycles with `pad_i`=32'hFFFFFFFF. During reset and on the first edge after release, `gpio_o`=0, `rise_o`=0, `event_o`=0.
- Debounced rise: bit 5, dir=in, en=1. Set pad 0->1 and hold. `gpio_o[5]` goes to 1 between edge 11 and edge 14 after the change. `rise_o[5]` and `event_o` are 1 for exactly that one cycle.
- Glitch rejection: bit 5, pad high for 6 cycles then low. `gpio_o[5]` stays 0, with no `rise_o`. After the pad is back low, `cnt` is 0 within 1 cycle of `sync` returning.
- FOLLOW paths:
  - Bit 7 with en=0: pad 0->1 gives `gpio_o[7]`=1 exactly 3 edges later, with `rise_o[7]` pulsed.
  - Bit 8 with dir=out: `gpio_o[8]` follows the pad in 3 edges and `rise_o[8]` stays 0.
- Simultaneous and mid-count:
  - Bits 0 and 31 fall together after being stable high: both `fall_o` pulse on the same edge, and `event_o` is 1 for one cycle.
  - A second bit with en cleared mid-PENDING takes the `sync` value on the next edge.
- Reset mid-debounce: assert `rst` 2 cycles into PENDING on bit 3. After release, `gpio_o[3]`=0, and acceptance requires a full 3-tick window again.
